// File: rtl/key_loader_pkg.sv
// Shared definitions for the key serial loader: state encoding, byte width
// and CRC-8 constants.
package key_loader_pkg;

  localparam int BYTE_W = 8;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BYTE = 2'd1,
    SHIFT     = 2'd2
  } loader_state_e;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (MSB first, no reflection, no final xor).
// One input bit is folded into the remainder on every cycle where en is set.
module crc8_serial
  import key_loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic feedback;

  assign feedback = crc[7] ^ din;

  // Remainder register: cleared on reset or clr, advanced one bit per enabled cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= CRC8_INIT;
    end else if (clr) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= {crc[6:0], 1'b0} ^ (feedback ? CRC8_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/key_serial_loader.sv
// Key serial loader: accepts key bytes on a valid/ready handshake and feeds
// them MSB-first into the downstream SIPO key register via shift/s_in.
// Optional feature macro: KEY_LOADER_CRC8_EN adds a running CRC-8 over the
// shifted bits; without it crc8 is tied to zero.
module key_serial_loader
  import key_loader_pkg::*;
#(
  parameter  int KEY_BITS = 256,
  localparam int CNT_W    = $clog2(KEY_BITS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              shift,
  output logic              s_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic [7:0]        crc8
);

  loader_state_e     state_q, state_d;
  logic [BYTE_W-1:0] buf_q, buf_d;
  logic [2:0]        bitIdx_q, bitIdx_d;
  logic              shift_q, shift_d;
  logic              sIn_q, sIn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // State and output registers; everything the loader drives comes from here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= 1'b0;
      sIn_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      sIn_q    <= sIn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic; the first bit of a byte is issued on the accepting edge
  // so shift is high for the eight cycles right after the handshake
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    bitIdx_d = bitIdx_q;
    shift_d  = 1'b0;
    sIn_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = WAIT_BYTE;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          count_d = '0;
        end
      end
      WAIT_BYTE: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else if (in_valid) begin
          state_d  = SHIFT;
          shift_d  = 1'b1;
          sIn_d    = in_data[BYTE_W-1];
          buf_d    = {in_data[BYTE_W-2:0], 1'b0};
          bitIdx_d = 3'd0;
          count_d  = count_q + 1'b1;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else if (bitIdx_q == 3'd7) begin
          if (count_q == CNT_W'(KEY_BITS)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT_BYTE;
          end
        end else begin
          shift_d  = 1'b1;
          sIn_d    = buf_q[BYTE_W-1];
          buf_d    = {buf_q[BYTE_W-2:0], 1'b0};
          bitIdx_d = bitIdx_q + 3'd1;
          count_d  = count_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign in_ready  = (state_q == WAIT_BYTE);
  assign shift     = shift_q;
  assign s_in      = sIn_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bit_count = count_q;

`ifdef KEY_LOADER_CRC8_EN
  logic crcClr;

  assign crcClr = (state_q == IDLE) && start && !abort;

  crc8_serial u_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (crcClr),
    .en    (shift_q),
    .din   (sIn_q),
    .crc   (crc8)
  );
`else
  assign crc8 = 8'h00;
`endif

endmodule

// File: tb/tb_key_serial_loader.sv
// Directed testbench for key_serial_loader with a behavioural SIPO model.
module tb_key_serial_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       shift;
  logic       s_in;
  logic       busy;
  logic       done;
  logic [8:0] bit_count;
  logic [7:0] crc8;

  int compared   = 0;
  int mismatched = 0;

  logic [255:0] sipo;
  int shiftPulses   = 0;
  int waitShiftViol = 0;
  int sInViol       = 0;

  key_serial_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .shift     (shift),
    .s_in      (s_in),
    .busy      (busy),
    .done      (done),
    .bit_count (bit_count),
    .crc8      (crc8)
  );

  always #5 clk = ~clk;

  // Behavioural SIPO plus protocol monitors, sampled mid-cycle
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      sipo = '0;
    end else if (shift) begin
      sipo = {sipo[254:0], s_in};
      shiftPulses++;
      if (in_ready) waitShiftViol++;
    end else if (s_in) begin
      sInViol++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] crcModel(input logic [7:0] base, input logic [7:0] step, input int n);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    b = base;
    for (int k = 0; k < n; k++) begin
      c = c ^ b;
      for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      b = b + step;
    end
    return c;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic startLoad();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, output bit ok);
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic waitDone(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    int base;
    int bad;
    applyReset();
    compared += 7;
    if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    if (shift !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_shift: got %b expected 0", shift); end
    if (s_in !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_s_in: got %b expected 0", s_in); end
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    if (bit_count !== 9'd0) begin mismatched++; $display("[TB] FAIL reset_bit_count: got %0d expected 0", bit_count); end
    if (crc8 !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_crc8: got %h expected 00", crc8); end
    base = shiftPulses;
    bad  = 0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    compared += 2;
    if (bad !== 0) begin mismatched++; $display("[TB] FAIL idle_outputs: got %0d bad cycles expected 0", bad); end
    if (shiftPulses - base !== 0) begin mismatched++; $display("[TB] FAIL idle_shift: got %0d pulses expected 0", shiftPulses - base); end
  endtask

  task automatic test_full_load();
    int base;
    bit ok;
    bit allOk;
    logic [255:0] expSipo;
    logic [7:0] expCrc;
    startLoad();
    base    = shiftPulses;
    allOk   = 1'b1;
    expSipo = '0;
    for (int k = 0; k < 32; k++) begin
      sendByte(8'(k), ok);
      allOk   = allOk & ok;
      expSipo = {expSipo[247:0], 8'(k)};
    end
    in_valid = 1'b0;
    waitDone(ok);
    allOk = allOk & ok;
`ifdef KEY_LOADER_CRC8_EN
    expCrc = crcModel(8'h00, 8'h01, 32);
`else
    expCrc = 8'h00;
`endif
    compared += 9;
    if (!allOk) begin mismatched++; $display("[TB] FAIL full_handshake: got timeout expected completion"); end
    if (shiftPulses - base !== 256) begin mismatched++; $display("[TB] FAIL full_pulses: got %0d expected 256", shiftPulses - base); end
    if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL full_done: got %b expected 1", done); end
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL full_busy: got %b expected 0", busy); end
    if (bit_count !== 9'd256) begin mismatched++; $display("[TB] FAIL full_bit_count: got %0d expected 256", bit_count); end
    if (sipo[255:248] !== 8'h00) begin mismatched++; $display("[TB] FAIL full_first_byte: got %h expected 00", sipo[255:248]); end
    if (sipo[7:0] !== 8'h1F) begin mismatched++; $display("[TB] FAIL full_last_byte: got %h expected 1f", sipo[7:0]); end
    if (sipo !== expSipo) begin mismatched++; $display("[TB] FAIL full_sipo: got %h expected %h", sipo, expSipo); end
    if (crc8 !== expCrc) begin mismatched++; $display("[TB] FAIL full_crc8: got %h expected %h", crc8, expCrc); end
  endtask

  task automatic test_single_byte();
    logic [7:0] pattern;
    bit ok;
    int bad;
    pattern = 8'hA5;
    startLoad();
    sendByte(pattern, ok);
    in_valid = 1'b0;
    compared++;
    if (!ok) begin mismatched++; $display("[TB] FAIL byte_handshake: got timeout expected accept"); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (shift !== 1'b1 || s_in !== pattern[7-i] || busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL byte_bit%0d: got shift=%b s_in=%b expected shift=1 s_in=%b", i, shift, s_in, pattern[7-i]);
      end
      tick();
    end
    compared++;
    if (bad !== 0) mismatched++;
    compared += 3;
    if (shift !== 1'b0) begin mismatched++; $display("[TB] FAIL byte_shift_end: got %b expected 0", shift); end
    if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL byte_ready_back: got %b expected 1", in_ready); end
    if (bit_count !== 9'd8) begin mismatched++; $display("[TB] FAIL byte_bit_count: got %0d expected 8", bit_count); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    compared += 2;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL byte_abort_idle: got busy=%b ready=%b expected 0 0", busy, in_ready); end
    if (bit_count !== 9'd8) begin mismatched++; $display("[TB] FAIL byte_abort_count: got %0d expected 8", bit_count); end
  endtask

  task automatic test_gaps();
    logic [255:0] expSipo;
    logic [7:0] b;
    int gap;
    int baseWait;
    int baseSin;
    bit ok;
    bit allOk;
    baseWait = waitShiftViol;
    baseSin  = sInViol;
    expSipo  = '0;
    allOk    = 1'b1;
    startLoad();
    for (int k = 0; k < 32; k++) begin
      gap = int'($urandom_range(0, 5));
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        in_data = 8'($urandom);
        tick();
      end
      b = 8'($urandom);
      sendByte(b, ok);
      allOk   = allOk & ok;
      expSipo = {expSipo[247:0], b};
      in_data = ~b;
    end
    in_valid = 1'b0;
    waitDone(ok);
    allOk = allOk & ok;
    compared += 5;
    if (!allOk) begin mismatched++; $display("[TB] FAIL gaps_handshake: got timeout expected completion"); end
    if (sipo !== expSipo) begin mismatched++; $display("[TB] FAIL gaps_sipo: got %h expected %h", sipo, expSipo); end
    if (waitShiftViol - baseWait !== 0) begin mismatched++; $display("[TB] FAIL gaps_shift_while_ready: got %0d expected 0", waitShiftViol - baseWait); end
    if (sInViol - baseSin !== 0) begin mismatched++; $display("[TB] FAIL gaps_s_in_idle: got %0d expected 0", sInViol - baseSin); end
    if (bit_count !== 9'd256) begin mismatched++; $display("[TB] FAIL gaps_bit_count: got %0d expected 256", bit_count); end
  endtask

  task automatic test_abort();
    bit reached;
    bit ok;
    bit allOk;
    startLoad();
    in_valid = 1'b1;
    in_data  = 8'h3C;
    reached  = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (bit_count == 9'd100) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    abort = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    compared += 5;
    if (!reached) begin mismatched++; $display("[TB] FAIL abort_reach100: got timeout expected bit_count 100"); end
    if (busy !== 1'b0 || in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_idle: got busy=%b ready=%b expected 0 0", busy, in_ready); end
    if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    if (shift !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_shift: got %b expected 0", shift); end
    if (bit_count !== 9'd100) begin mismatched++; $display("[TB] FAIL abort_bit_count: got %0d expected 100", bit_count); end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    compared++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || bit_count !== 9'd100) begin
      mismatched++;
      $display("[TB] FAIL start_abort_idle: got busy=%b ready=%b count=%0d expected 0 0 100", busy, in_ready, bit_count);
    end
    startLoad();
    allOk = 1'b1;
    for (int k = 0; k < 32; k++) begin
      sendByte(8'(8'hC0 + k), ok);
      allOk = allOk & ok;
    end
    in_valid = 1'b0;
    waitDone(ok);
    allOk = allOk & ok;
    compared += 3;
    if (!allOk) begin mismatched++; $display("[TB] FAIL reload_handshake: got timeout expected completion"); end
    if (bit_count !== 9'd256) begin mismatched++; $display("[TB] FAIL reload_bit_count: got %0d expected 256", bit_count); end
    if (sipo[255:248] !== 8'hC0 || sipo[7:0] !== 8'hDF) begin mismatched++; $display("[TB] FAIL reload_sipo: got %h..%h expected c0..df", sipo[255:248], sipo[7:0]); end
  endtask

  task automatic test_crc();
    logic [7:0] expCrc;
    bit ok;
    bit allOk;
`ifdef KEY_LOADER_CRC8_EN
    expCrc = crcModel(8'hFF, 8'h00, 32);
`else
    expCrc = 8'h00;
`endif
    startLoad();
    compared++;
    if (crc8 !== 8'h00) begin mismatched++; $display("[TB] FAIL crc_cleared_on_start: got %h expected 00", crc8); end
    allOk = 1'b1;
    for (int k = 0; k < 32; k++) begin
      sendByte(8'hFF, ok);
      allOk = allOk & ok;
    end
    in_valid = 1'b0;
    waitDone(ok);
    allOk = allOk & ok;
    compared += 2;
    if (!allOk) begin mismatched++; $display("[TB] FAIL crc_handshake: got timeout expected completion"); end
    if (crc8 !== expCrc) begin mismatched++; $display("[TB] FAIL crc_value: got %h expected %h", crc8, expCrc); end
  endtask

  task automatic test_reset_mid_shift();
    bit seen;
    startLoad();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (shift) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    compared += 2;
    if (!seen) begin mismatched++; $display("[TB] FAIL midreset_shift_seen: got timeout expected shift"); end
    if (in_ready !== 1'b0 || shift !== 1'b0 || s_in !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || bit_count !== 9'd0 || crc8 !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL midreset_outputs: got rdy=%b sh=%b sin=%b busy=%b done=%b cnt=%0d crc=%h expected all 0",
               in_ready, shift, s_in, busy, done, bit_count, crc8);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_full_load();
    test_single_byte();
    test_gaps();
    test_abort();
    test_crc();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
